// File: rtl/data_mem_bytelane.sv
// Byte-lane data memory with a fixed-latency request/response port.
// Loads and stores of byte/halfword/word with alignment, range and size faults.
module data_mem_bytelane #(
    parameter int DEPTH_WORDS = 4096,
    parameter int WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_fault,
    output logic [1:0]  dbg_state
);

    localparam int         AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0] WS = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, uns_q;
    logic [1:0]  size_q;
    logic [31:0] addr_q, wdata_q;
    logic [31:0] rdata_q;
    logic        fault_q;

    logic [31:0] mem [DEPTH_WORDS];

    // Handshake: a request transfers on a rising edge where req_valid && req_ready
    // (and rst is low); req_ready is high only in IDLE. The response is a one-cycle
    // resp_valid strobe that cannot be stalled.
    logic accept;
    assign accept    = req_valid && (state_q == S_IDLE);
    assign req_ready = (state_q == S_IDLE);
    assign dbg_state = state_q;

    // With zero wait states RESP is entered on the accept edge, before the request
    // registers are loaded, so the operation comes straight from the port in IDLE.
    logic        op_we, op_uns;
    logic [1:0]  op_size;
    logic [31:0] op_addr, op_wdata;
    assign op_we    = (state_q == S_IDLE) ? req_we       : we_q;
    assign op_uns   = (state_q == S_IDLE) ? req_unsigned : uns_q;
    assign op_size  = (state_q == S_IDLE) ? req_size     : size_q;
    assign op_addr  = (state_q == S_IDLE) ? req_addr     : addr_q;
    assign op_wdata = (state_q == S_IDLE) ? req_wdata    : wdata_q;

    logic          op_fault;
    logic [AW-1:0] op_idx;
    logic [31:0]   rd_word, rd_shift, wd_shift, load_data;
    logic [3:0]    be;
    logic          enter_resp;

    assign op_fault = ((op_size == 2'b01) && op_addr[0])
                   || ((op_size == 2'b10) && (op_addr[1:0] != 2'b00))
                   || (op_size == 2'b11)
                   || ({2'b00, op_addr[31:2]} >= 32'(DEPTH_WORDS));
    assign op_idx   = op_addr[AW+1:2];
    assign rd_word  = mem[op_idx];
    assign rd_shift = rd_word >> {op_addr[1:0], 3'b000};
    assign wd_shift = op_wdata << {op_addr[1:0], 3'b000};

    always_comb begin
        load_data = rd_shift;
        be        = 4'b1111;
        case (op_size)
            2'b00: begin
                load_data = op_uns ? {24'h0, rd_shift[7:0]} : {{24{rd_shift[7]}}, rd_shift[7:0]};
                be        = 4'b0001 << op_addr[1:0];
            end
            2'b01: begin
                load_data = op_uns ? {16'h0, rd_shift[15:0]} : {{16{rd_shift[15]}}, rd_shift[15:0]};
                be        = 4'b0011 << op_addr[1:0];
            end
            default: begin
                load_data = rd_shift;
                be        = 4'b1111;
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    if (WS == 4'd0) begin
                        state_d = S_RESP;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = WS;
                    end
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) state_d = S_RESP;
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign enter_resp = (state_d == S_RESP) && (state_q != S_RESP) && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            rdata_q <= 32'h0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                we_q    <= req_we;
                uns_q   <= req_unsigned;
                size_q  <= req_size;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
            if (enter_resp) begin
                rdata_q <= (op_fault || op_we) ? 32'h0 : load_data;
                fault_q <= op_fault;
            end
        end
    end

    // Memory contents survive reset; a reset on the write edge suppresses the store.
    always_ff @(posedge clk) begin
        if (enter_resp && op_we && !op_fault) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[op_idx][8*i +: 8] <= wd_shift[8*i +: 8];
            end
        end
    end

    assign resp_valid = (state_q == S_RESP);
    assign resp_rdata = resp_valid ? rdata_q : 32'h0;
    assign resp_fault = resp_valid ? fault_q : 1'b0;

endmodule
